// File: rtl/sample_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo_pkg
// Purpose  : Shared constants, types and helpers for the sample replay FIFO.
//            RD_LAT_MAX - largest supported read latency
//            vld_sr_t   - read-valid shift register, one bit per read stage
//            ptr_diff   - wrap-safe pointer difference for w-bit pointers
// Revision : 1.0 - initial release
// ============================================================================
package sample_fifo_pkg;

   localparam int unsigned RD_LAT_MAX = 2;

   typedef logic [RD_LAT_MAX-1:0] vld_sr_t;

   // Pointers wrap modulo 2**w, so the difference is taken in 32 bits and
   // then masked back to the pointer width.
   function automatic int unsigned ptr_diff(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned w);
      int unsigned mask;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (a - b) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo_ram
// Purpose  : Inferred simple dual-port RAM (one write, one read port) with
//            RD_LAT read register stages. Only the final output register is
//            reset; the array and any intermediate stage are not.
// Ports    : clk, rst_n         - clock, synchronous active-low reset
//            i_wr_en/addr/data  - write port
//            i_rd_en/i_rd_addr  - read request, loads the first read stage
//            i_adv              - advances stage 1 into the output (RD_LAT=2)
//            o_rd_data          - output register, holds when not loaded
// Revision : 1.0 - initial release
// ============================================================================
module sample_fifo_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic              i_adv,
   output logic [DATA_W-1:0] o_rd_data
);

   localparam int c_depth = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [c_depth];
   logic [DATA_W-1:0] r_out;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         // Single stage: the array read lands directly in the output register.
         logic w_unused_adv;
         assign w_unused_adv = i_adv;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_out <= '0;
            end else if (i_rd_en) begin
               r_out <= r_mem[i_rd_addr];
            end
         end
      end else begin : g_lat2
         logic [DATA_W-1:0] r_stage;

         always_ff @(posedge clk) begin
            if (i_rd_en) begin
               r_stage <= r_mem[i_rd_addr];
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_out <= '0;
            end else if (i_adv) begin
               r_out <= r_stage;
            end
         end
      end
   endgenerate

   assign o_rd_data = r_out;

endmodule
`default_nettype wire

// File: rtl/sample_replay_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_replay_fifo
// Purpose  : Sample FIFO with mark/rewind replay so a batch of feature samples
//            can be streamed to several tree engines without reloading.
//            Entries between the mark and the write pointer are protected.
// Config   : `define SAMPLE_FIFO_REPLAY_EN enables mark/rewind/release; when
//            undefined those inputs are ignored and it is a plain FIFO.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            i_flush             - empty FIFO, drop mark, kill pending reads
//            i_push / i_rear     - write request and data
//            i_pop               - read request
//            i_mark / i_rewind / i_release - replay control
//            o_front / o_vld     - read data and its one-cycle valid
//            o_full / o_empty / o_count    - occupancy
//            o_err               - sticky push-while-full / pop-while-empty
// Revision : 1.0 - initial release
// ============================================================================
module sample_replay_fifo
   import sample_fifo_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_flush,
   input  logic                i_push,
   input  logic [DATA_W-1:0]   i_rear,
   input  logic                i_pop,
   input  logic                i_mark,
   input  logic                i_rewind,
   input  logic                i_release,
   output logic [DATA_W-1:0]   o_front,
   output logic                o_vld,
   output logic                o_full,
   output logic                o_empty,
   output logic [DEPTH_LOG2:0] o_count,
   output logic                o_err
);

   localparam int          c_ptr_w    = DEPTH_LOG2 + 1;
   localparam int unsigned c_depth    = 32'd1 << DEPTH_LOG2;
   localparam vld_sr_t     c_vld_mask = vld_sr_t'((32'd1 << RD_LAT) - 32'd1);
   localparam logic [c_ptr_w-1:0] c_one = c_ptr_w'(1);

   logic [c_ptr_w-1:0] r_rptr;
   logic [c_ptr_w-1:0] r_wptr;
   logic               r_err;
   vld_sr_t            r_vld;

   logic [c_ptr_w-1:0] w_base;
   logic [c_ptr_w-1:0] w_rewind_ptr;
   logic [c_ptr_w-1:0] w_count;
   logic               w_rewind;
   logic               w_empty;
   logic               w_full;
   logic               w_pop_req;
   logic               w_pop_acc;
   logic               w_pop_bad;
   logic               w_push_acc;
   logic               w_push_bad;
   logic               w_adv;
   logic               w_unused_vld;

`ifdef SAMPLE_FIFO_REPLAY_EN
   logic [c_ptr_w-1:0] r_mark_ptr;
   logic               r_mark_active;

   // While a mark is held, free space is measured from the mark so the
   // replayable window can never be overwritten.
   assign w_base       = r_mark_active ? r_mark_ptr : r_rptr;
   // Rewind without an active mark does nothing at all (pop still proceeds).
   assign w_rewind     = i_rewind & r_mark_active;
   assign w_rewind_ptr = r_mark_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_mark_ptr    <= '0;
         r_mark_active <= 1'b0;
      end else if (i_release) begin
         r_mark_active <= 1'b0;
      end else if (i_mark && !w_rewind) begin
         // Pre-pop pointer, so an entry popped in this same cycle is replayable.
         r_mark_ptr    <= r_rptr;
         r_mark_active <= 1'b1;
      end
   end
`else
   logic w_unused_replay;
   assign w_unused_replay = i_mark ^ i_rewind ^ i_release;
   assign w_base          = r_rptr;
   assign w_rewind        = 1'b0;
   assign w_rewind_ptr    = r_rptr;
`endif

   assign w_count = c_ptr_w'(ptr_diff(32'(r_wptr), 32'(r_rptr), 32'(c_ptr_w)));
   assign w_empty = (r_rptr == r_wptr);
   assign w_full  = (ptr_diff(32'(r_wptr), 32'(w_base), 32'(c_ptr_w)) == c_depth);

   // Flush outranks everything; an effective rewind swallows a same-cycle pop.
   assign w_pop_req  = i_pop & ~i_flush & ~w_rewind;
   assign w_pop_acc  = w_pop_req & ~w_empty;
   assign w_pop_bad  = w_pop_req &  w_empty;
   assign w_push_acc = i_push & ~i_flush & ~w_full;
   assign w_push_bad = i_push & ~i_flush &  w_full;

   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_rptr <= '0;
         r_wptr <= '0;
         r_err  <= 1'b0;
         r_vld  <= '0;
      end else begin
         if (w_rewind) begin
            r_rptr <= w_rewind_ptr;
         end else if (w_pop_acc) begin
            r_rptr <= r_rptr + c_one;
         end
         if (w_push_acc) begin
            r_wptr <= r_wptr + c_one;
         end
         if (w_pop_bad || w_push_bad) begin
            r_err <= 1'b1;
         end
         r_vld <= {r_vld[0], w_pop_acc} & c_vld_mask;
      end
   end

   // Second read stage only advances for a live read that is not being flushed.
   assign w_adv        = r_vld[0] & ~i_flush;
   assign w_unused_vld = ^r_vld;

   sample_fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (DEPTH_LOG2),
      .RD_LAT (RD_LAT)
   ) u_ram (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_push_acc),
      .i_wr_addr (r_wptr[DEPTH_LOG2-1:0]),
      .i_wr_data (i_rear),
      .i_rd_en   (w_pop_acc),
      .i_rd_addr (r_rptr[DEPTH_LOG2-1:0]),
      .i_adv     (w_adv),
      .o_rd_data (o_front)
   );

   assign o_vld   = r_vld[RD_LAT-1];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = w_count;
   assign o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sample_replay_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_replay_fifo
// Purpose  : Self-checking bench for sample_replay_fifo. Two instances with
//            DEPTH_LOG2=2 (RD_LAT=1 and RD_LAT=2) share one input stream and
//            are compared against a sequence-number reference model, plus a
//            directed table and hand-written replay sequences.
// Config   : follows `define SAMPLE_FIFO_REPLAY_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_replay_fifo;

   localparam int DEPTH = 4;
`ifdef SAMPLE_FIFO_REPLAY_EN
   localparam bit REPLAY = 1'b1;
`else
   localparam bit REPLAY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0;
   logic        mark = 1'b0, rewind = 1'b0, rel = 1'b0;
   logic [15:0] rear = '0;
   logic [15:0] front1, front2;
   logic        vld1, vld2, full1, full2, empty1, empty2, err1, err2;
   logic [2:0]  cnt1, cnt2;

   sample_replay_fifo #(.DATA_W(16), .DEPTH_LOG2(2), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_push(push), .i_rear(rear),
      .i_pop(pop), .i_mark(mark), .i_rewind(rewind), .i_release(rel),
      .o_front(front1), .o_vld(vld1), .o_full(full1), .o_empty(empty1),
      .o_count(cnt1), .o_err(err1));

   sample_replay_fifo #(.DATA_W(16), .DEPTH_LOG2(2), .RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_push(push), .i_rear(rear),
      .i_pop(pop), .i_mark(mark), .i_rewind(rewind), .i_release(rel),
      .o_front(front2), .o_vld(vld2), .o_full(full2), .o_empty(empty2),
      .o_count(cnt2), .o_err(err2));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: every accepted push gets an absolute sequence number;
   // pointers are plain unbounded integers into that history.
   int          m_rd, m_wr, m_mark;
   bit          m_mact, m_err;
   logic [15:0] hist[$];
   bit          e_v1, e_v2, e_v2a;
   logic [15:0] e_f1, e_f2, e_d2a;

   task automatic model_clear();
      m_rd = 0; m_wr = 0; m_mark = 0; m_mact = 0; m_err = 0;
      hist.delete();
      e_v1 = 0; e_v2 = 0; e_v2a = 0;
   endtask

   task automatic model_update();
      int base;
      bit full, empty, rew, pop_ok, pop_bad, push_ok, push_bad;
      logic [15:0] pd;
      if (!rst_n) begin
         model_clear();
         e_f1 = '0; e_f2 = '0;
         return;
      end
      if (flush) begin
         model_clear();
         return;
      end
      base     = (REPLAY && m_mact) ? m_mark : m_rd;
      full     = (m_wr - base) == DEPTH;
      empty    = (m_rd == m_wr);
      rew      = REPLAY && rewind && m_mact;
      pop_ok   = pop && !rew && !empty;
      pop_bad  = pop && !rew && empty;
      push_ok  = push && !full;
      push_bad = push && full;
      pd       = pop_ok ? hist[m_rd] : 16'h0;
      e_v2 = e_v2a;
      if (e_v2a) e_f2 = e_d2a;
      e_v2a = pop_ok;
      if (pop_ok) e_d2a = pd;
      e_v1 = pop_ok;
      if (pop_ok) e_f1 = pd;
      if (REPLAY) begin
         if (rel) m_mact = 0;
         else if (mark && !rew) begin m_mark = m_rd; m_mact = 1; end
      end
      m_rd = rew ? m_mark : m_rd + int'(pop_ok);
      if (push_ok) begin hist.push_back(rear); m_wr++; end
      if (push_bad || pop_bad) m_err = 1;
   endtask

   task automatic model_check();
      int  base;
      bit  efull, eempty;
      base   = (REPLAY && m_mact) ? m_mark : m_rd;
      efull  = (m_wr - base) == DEPTH;
      eempty = (m_rd == m_wr);
      check("d1_vld",   vld1,   e_v1);
      check("d1_front", front1, e_f1);
      check("d1_count", cnt1,   m_wr - m_rd);
      check("d1_full",  full1,  efull);
      check("d1_empty", empty1, eempty);
      check("d1_err",   err1,   m_err);
      check("d2_vld",   vld2,   e_v2);
      check("d2_front", front2, e_f2);
      check("d2_count", cnt2,   m_wr - m_rd);
      check("d2_full",  full2,  efull);
      check("d2_empty", empty2, eempty);
      check("d2_err",   err2,   m_err);
   endtask

   task automatic step(input logic r, input logic f, input logic pu, input logic [15:0] d,
                       input logic po, input logic mk, input logic rw, input logic rl);
      @(negedge clk);
      rst_n = r; flush = f; push = pu; rear = d; pop = po;
      mark = mk; rewind = rw; rel = rl;
      @(posedge clk);
      model_update();
      #1;
      model_check();
   endtask

   task automatic do_push(input logic [15:0] d); step(1, 0, 1, d, 0, 0, 0, 0); endtask
   task automatic do_pop();                      step(1, 0, 0, 0, 1, 0, 0, 0); endtask
   task automatic do_flush();                    step(1, 1, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_idle();                     step(1, 0, 0, 0, 0, 0, 0, 0); endtask

   typedef struct {
      logic        flush, push, pop;
      logic [15:0] d;
      logic [2:0]  cnt;
      logic        full, empty, err, vld;
      logic [15:0] front;
   } vec_t;

   vec_t tbl[12];

   initial begin
      //        flush push pop data     cnt full empty err vld front
      tbl[0]  = '{0, 1, 0, 16'h0011, 3'd1, 0, 0, 0, 0, 16'h0000};
      tbl[1]  = '{0, 1, 0, 16'h0022, 3'd2, 0, 0, 0, 0, 16'h0000};
      tbl[2]  = '{0, 1, 0, 16'h0033, 3'd3, 0, 0, 0, 0, 16'h0000};
      tbl[3]  = '{0, 1, 0, 16'h0044, 3'd4, 1, 0, 0, 0, 16'h0000};
      tbl[4]  = '{0, 1, 0, 16'h0055, 3'd4, 1, 0, 1, 0, 16'h0000};
      tbl[5]  = '{0, 0, 1, 16'h0000, 3'd3, 0, 0, 1, 1, 16'h0011};
      tbl[6]  = '{0, 0, 1, 16'h0000, 3'd2, 0, 0, 1, 1, 16'h0022};
      tbl[7]  = '{0, 0, 1, 16'h0000, 3'd1, 0, 0, 1, 1, 16'h0033};
      tbl[8]  = '{0, 0, 1, 16'h0000, 3'd0, 0, 1, 1, 1, 16'h0044};
      tbl[9]  = '{0, 0, 0, 16'h0000, 3'd0, 0, 1, 1, 0, 16'h0044};
      tbl[10] = '{0, 0, 1, 16'h0000, 3'd0, 0, 1, 1, 0, 16'h0044};
      tbl[11] = '{1, 0, 0, 16'h0000, 3'd0, 0, 1, 0, 0, 16'h0044};

      // Reset
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 16'hBEEF, 1, 0, 0, 0);
      check("rst_empty", empty1, 1);
      check("rst_full",  full1,  0);
      check("rst_count", cnt1,   0);
      check("rst_vld",   vld2,   0);
      check("rst_front", front2, 0);

      // Directed table: fill, overflow, drain, underflow, flush
      for (int i = 0; i < 12; i++) begin
         step(1, tbl[i].flush, tbl[i].push, tbl[i].d, tbl[i].pop, 0, 0, 0);
         check($sformatf("tbl%0d_count", i), cnt1,   tbl[i].cnt);
         check($sformatf("tbl%0d_full", i),  full1,  tbl[i].full);
         check($sformatf("tbl%0d_empty", i), empty1, tbl[i].empty);
         check($sformatf("tbl%0d_err", i),   err1,   tbl[i].err);
         check($sformatf("tbl%0d_vld", i),   vld1,   tbl[i].vld);
         check($sformatf("tbl%0d_front", i), front1, tbl[i].front);
      end

`ifdef SAMPLE_FIFO_REPLAY_EN
      // Mark at rptr=0 together with the first pop, pop 3, rewind, pop 3 again
      for (int i = 1; i <= 4; i++) do_push(16'(i * 16'h11));
      step(1, 0, 0, 0, 1, 1, 0, 0);
      check("rp_first", front1, 16'h0011);
      do_pop(); do_pop();
      check("rp_third", front1, 16'h0033);
      check("rp_prot_full", full1, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      check("rp_rewind_count", cnt1, 4);
      for (int i = 1; i <= 3; i++) begin
         do_pop();
         check($sformatf("rp_replay%0d", i), front1, 16'(i * 16'h11));
      end
      // Pop together with rewind: pop dropped, rptr back at mark
      step(1, 0, 0, 0, 1, 0, 1, 0);
      check("rw_pop_vld", vld1, 0);
      check("rw_pop_count", cnt1, 4);
      check("rw_pop_err", err1, 0);

      // Protection of the marked window, then release
      do_flush();
      do_push(16'hA1); do_push(16'hA2);
      step(1, 0, 0, 0, 0, 1, 0, 0);
      do_pop(); do_pop();
      do_push(16'hA3); do_push(16'hA4);
      check("prot_full", full1, 1);
      check("prot_count", cnt1, 2);
      do_push(16'hA5);
      check("prot_rej_err", err1, 1);
      check("prot_rej_count", cnt1, 2);
      step(1, 0, 0, 0, 0, 1, 0, 1);
      check("rel_full", full1, 0);
      do_push(16'hA6); do_push(16'hA7);
      check("rel_count", cnt1, 4);
      do_pop();
      check("rel_data", front1, 16'hA3);
`else
      // Replay controls ignored: full is relative to rptr
      do_push(16'h11); do_push(16'h22); do_pop();
      step(1, 0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      check("nr_rewind_count", cnt1, 1);
      do_push(16'h33); do_push(16'h44); do_push(16'h55);
      check("nr_full", full1, 1);
      check("nr_count", cnt1, 4);
      step(1, 0, 0, 0, 1, 0, 1, 0);
      check("nr_rw_pop_vld", vld1, 1);
      check("nr_rw_pop_data", front1, 16'h22);
`endif

      // Streaming push+pop with one entry resident, across pointer wraps
      do_flush();
      do_push(16'h1000);
      for (int i = 1; i <= 20; i++) begin
         step(1, 0, 1, 16'(16'h1000 + i), 1, 0, 0, 0);
         check($sformatf("stream%0d_count", i), cnt1, 1);
         check($sformatf("stream%0d_data", i), front1, 16'(16'h1000 + i - 1));
      end
      check("stream_err", err1, 0);

      // Flush with reads in flight on the latency-2 instance
      do_flush();
      do_push(16'h0B01); do_push(16'h0B02);
      do_pop(); do_pop();
      do_flush();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("flush_novld%0d", i), vld2, 0);
         do_idle();
      end
      check("flush_empty", empty2, 1);
      check("flush_err", err2, 0);
      check("flush_front_hold", front2, 16'h0B01);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 300) != 0, ($urandom % 70) == 0,
              ($urandom % 100) < 55, 16'($urandom),
              ($urandom % 100) < 50, ($urandom % 20) == 0,
              ($urandom % 25) == 0, ($urandom % 30) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
